// File: rtl/imem_dmem_arbiter.sv
// Shares one single-port memory between the fetch (I) and load/store (D) requesters.
// Data port has priority. An anti-starvation counter and per-port response masking keep both ports served.
module imem_dmem_arbiter #(
  parameter int MEMSIZE    = 131072,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        resetb,
  input  logic        i_valid,
  input  logic [31:0] i_addr,
  output logic        i_ready,
  output logic [31:0] i_rdata,
  input  logic        d_valid,
  input  logic [31:0] d_addr,
  input  logic [3:0]  d_wstrb,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  output logic        m_rready,
  output logic [29:0] m_raddr,
  output logic [29:0] m_waddr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  input  logic [31:0] m_rdata,
  output logic        err,
  output logic [31:0] err_addr
);

  localparam int AW = $clog2(MEMSIZE);
  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

  logic          pend_i, pend_d;
  logic          rd_i, rd_d;
  logic          flt_i, flt_d;
  logic [CW-1:0] starve_cnt;

  logic          elig_i, elig_d;
  logic          gnt_i, gnt_d;
  logic          gnt_wr, gnt_flt;
  logic [31:0]   gnt_addr;

  // Gating with resetb keeps the combinational memory strobes quiet while reset is held
  always_comb begin
    elig_i   = resetb & i_valid & ~pend_i;
    elig_d   = resetb & d_valid & ~pend_d;
    gnt_d    = elig_d & ~(elig_i & (starve_cnt == CNT_MAX));
    gnt_i    = elig_i & ~gnt_d;
    gnt_addr = gnt_d ? d_addr : (gnt_i ? i_addr : '0);
    gnt_flt  = |gnt_addr[31:AW];
    gnt_wr   = gnt_d & (|d_wstrb);
    m_rready = (gnt_i | (gnt_d & ~gnt_wr)) & ~gnt_flt;
    m_raddr  = gnt_addr[31:2];
    m_waddr  = gnt_addr[31:2];
    m_wstrb  = (gnt_wr & ~gnt_flt) ? d_wstrb : '0;
    m_wdata  = (gnt_wr & ~gnt_flt) ? d_wdata : '0;
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      pend_i     <= 1'b0;
      pend_d     <= 1'b0;
      rd_i       <= 1'b0;
      rd_d       <= 1'b0;
      flt_i      <= 1'b0;
      flt_d      <= 1'b0;
      err_addr   <= '0;
      starve_cnt <= '0;
    end else begin
      pend_i <= gnt_i;
      pend_d <= gnt_d;
      rd_i   <= gnt_i & ~gnt_flt;
      rd_d   <= gnt_d & ~gnt_wr & ~gnt_flt;
      flt_i  <= gnt_i & gnt_flt;
      flt_d  <= gnt_d & gnt_flt;
      if (gnt_flt)
        err_addr <= gnt_addr;
      if (gnt_i || !i_valid)
        starve_cnt <= '0;
      else if (gnt_d && elig_i && starve_cnt != CNT_MAX)
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

  always_comb begin
    i_ready = pend_i;
    d_ready = pend_d;
    i_rdata = rd_i ? m_rdata : '0;
    d_rdata = rd_d ? m_rdata : '0;
    err     = (pend_i & flt_i) | (pend_d & flt_d);
  end

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Randomized bench for imem_dmem_arbiter: a memory environment plus a reference model
// built from the arbitration, range and response rules, checked every cycle.
module tb_imem_dmem_arbiter;

  localparam int MEMSIZE    = 131072;
  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        resetb;
  logic        i_valid, d_valid;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [3:0]  d_wstrb;
  logic        i_ready, d_ready, m_rready, err;
  logic [31:0] i_rdata, d_rdata, m_wdata, err_addr;
  logic [29:0] m_raddr, m_waddr;
  logic [3:0]  m_wstrb;
  logic [31:0] m_rdata = '0;

  int n_cmp = 0;
  int n_bad = 0;

  imem_dmem_arbiter #(.MEMSIZE(MEMSIZE), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .resetb(resetb),
    .i_valid(i_valid), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
    .d_valid(d_valid), .d_addr(d_addr), .d_wstrb(d_wstrb), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .m_rready(m_rready), .m_raddr(m_raddr), .m_waddr(m_waddr), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_rdata(m_rdata), .err(err), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  // Memory environment: registered read, byte-strobed write
  logic [31:0] mem_env [0:32767];
  always @(posedge clk) begin
    if (m_rready) m_rdata <= mem_env[m_raddr[14:0]];
    for (int b = 0; b < 4; b++)
      if (m_wstrb[b]) mem_env[m_waddr[14:0]][8*b +: 8] <= m_wdata[8*b +: 8];
  end

  // Reference model state
  logic [31:0] refmem [0:255];
  bit          last_gi, last_gd;
  int          mcnt;
  bit          er_i_v, er_i_err, er_d_v, er_d_err;
  logic [31:0] er_i_data, er_d_data, m_err_addr;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic reset_model();
    last_gi = 0; last_gd = 0; mcnt = 0;
    er_i_v = 0; er_i_err = 0; er_i_data = '0;
    er_d_v = 0; er_d_err = 0; er_d_data = '0;
    m_err_addr = '0;
  endtask

  // One clock: check at negedge against the model, advance model, return at posedge+1
  task automatic step();
    bit ei, ed, gi, gd, flt, wr, ping, pingd;
    logic [31:0] a, rv;
    @(negedge clk);
    check_val("i_ready", {31'b0, i_ready}, {31'b0, er_i_v});
    check_val("i_rdata", i_rdata, er_i_v ? er_i_data : 32'h0);
    check_val("d_ready", {31'b0, d_ready}, {31'b0, er_d_v});
    check_val("d_rdata", d_rdata, er_d_v ? er_d_data : 32'h0);
    check_val("err", {31'b0, err}, {31'b0, (er_i_v && er_i_err) || (er_d_v && er_d_err)});
    check_val("err_addr", err_addr, m_err_addr);

    // A port granted last cycle sits out this one
    ei = resetb && i_valid && !last_gi;
    ed = resetb && d_valid && !last_gd;
    gd = ed && !(ei && mcnt == STARVE_MAX);
    gi = ei && !gd;
    a   = gd ? d_addr : (gi ? i_addr : 32'h0);
    flt = (gi || gd) && (a >= 32'(MEMSIZE));
    wr  = gd && (d_wstrb != 4'b0);
    ping  = gi && !flt;
    pingd = gd && !wr && !flt;

    check_val("m_rready", {31'b0, m_rready}, {31'b0, ping || pingd});
    check_val("m_raddr", {2'b0, m_raddr}, {2'b0, a[31:2]});
    check_val("m_waddr", {2'b0, m_waddr}, {2'b0, a[31:2]});
    check_val("m_wstrb", {28'b0, m_wstrb}, {28'b0, (wr && !flt) ? d_wstrb : 4'b0});
    if (wr && !flt) check_val("m_wdata", m_wdata, d_wdata);

    rv = refmem[a[9:2]];
    er_i_v = gi; er_i_err = gi && flt; er_i_data = ping ? rv : 32'h0;
    er_d_v = gd; er_d_err = gd && flt; er_d_data = pingd ? rv : 32'h0;
    if (flt) m_err_addr = a;
    if (wr && !flt)
      for (int b = 0; b < 4; b++)
        if (d_wstrb[b]) refmem[a[9:2]][8*b +: 8] = d_wdata[8*b +: 8];
    if (gi || !i_valid) mcnt = 0;
    else if (gd && ei && mcnt < STARVE_MAX) mcnt++;
    last_gi = gi; last_gd = gd;
    if (!resetb) reset_model();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(7) == 0) return $urandom | 32'h0002_0000;
    return {22'b0, 8'($urandom_range(255)), 2'($urandom_range(3))};
  endfunction

  task automatic new_i();
    i_valid = ($urandom_range(3) != 0);
    i_addr  = rand_addr();
  endtask

  task automatic new_d();
    d_valid = ($urandom_range(3) != 0);
    d_addr  = rand_addr();
    d_wstrb = $urandom_range(1) ? 4'b0 : 4'($urandom_range(15));
    d_wdata = $urandom;
  endtask

  initial begin
    bit i_rsp, d_rsp;
    logic [31:0] v;
    for (int w = 0; w < 256; w++) begin
      v = $urandom;
      if (w == 4) v = 32'h0050_0093;
      if (w == 8) v = 32'h0;
      mem_env[w] = v;
      refmem[w]  = v;
    end
    resetb = 1'b0;
    i_valid = 0; i_addr = '0; d_valid = 0; d_addr = '0; d_wstrb = '0; d_wdata = '0;
    reset_model();
    #23;
    check_val("rst_i_ready", {31'b0, i_ready}, 32'h0);
    check_val("rst_d_ready", {31'b0, d_ready}, 32'h0);
    check_val("rst_m_rready", {31'b0, m_rready}, 32'h0);
    check_val("rst_err", {31'b0, err}, 32'h0);
    check_val("rst_err_addr", err_addr, 32'h0);
    resetb = 1'b1;
    @(posedge clk); #1;

    // Lone fetch, then held valid must not be re-granted
    i_valid = 1; i_addr = 32'h10;
    step(); step();
    i_valid = 0; step();

    // Contention: D first, I next cycle
    i_valid = 1; i_addr = 32'h0; d_valid = 1; d_addr = 32'h100; d_wstrb = 0;
    step(); step();
    d_valid = 0; step();
    i_valid = 0; step();

    // Partial write then read-back merge
    d_valid = 1; d_addr = 32'h20; d_wstrb = 4'b0011; d_wdata = 32'hAABB_CCDD;
    step(); step();
    d_wstrb = 4'b0; step(); step();
    d_valid = 0; step();

    // Both held high: I must break through
    i_valid = 1; i_addr = 32'h44; d_valid = 1; d_addr = 32'h88; d_wstrb = 0;
    for (int k = 0; k < 12; k++) step();
    i_valid = 0; d_valid = 0; step(); step();

    // Out-of-range fetch
    i_valid = 1; i_addr = 32'h0002_0000;
    step(); step();
    i_valid = 0; step();

    // Reset just after a D grant
    d_valid = 1; d_addr = 32'h40; d_wstrb = 0;
    step();
    resetb = 1'b0; d_valid = 0;
    reset_model();
    step();
    check_val("rstmid_err_addr", err_addr, 32'h0);
    resetb = 1'b1;
    i_valid = 1; i_addr = 32'h0;
    step(); step();
    i_valid = 0; step();

    // Randomized traffic with held-until-ready requesters
    i_rsp = 0; d_rsp = 0;
    new_i(); new_d();
    for (int k = 0; k < 600; k++) begin
      step();
      if (last_gi) begin
        i_rsp = 1;
        if ($urandom_range(1) == 0) i_valid = 0;
      end else if (i_rsp || !i_valid) begin
        i_rsp = 0;
        new_i();
      end
      if (last_gd) begin
        d_rsp = 1;
        if ($urandom_range(1) == 0) d_valid = 0;
      end else if (d_rsp || !d_valid) begin
        d_rsp = 0;
        new_d();
      end
    end
    i_valid = 0; d_valid = 0;
    step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/imem_dmem_arbiter.md
Name: imem_dmem_arbiter

Overview:
- Shares one single-port memory model (30-bit word address, 1-cycle registered read) between the IF fetch requester (I-port) and the load/store requester (D-port).
- Sits between the IF_ID/EX stages and the memory model.
- Arbitrates with data priority and an anti-starvation counter, masks a requester during its response cycle, and flags out-of-range addresses instead of issuing them.

Parameters:
- MEMSIZE, 131072: memory size in bytes. Address bits [31:$clog2(MEMSIZE)] must be zero.
- STARVE_MAX, 4: number of consecutive contended D grants after which the I-port wins the next contention.

Ports:
- clk  in  1  clock
- resetb  in  1  asynchronous, active-low reset
- i_valid  in  1  fetch request; held until i_ready
- i_addr  in  32  fetch byte address
- i_ready  out  1  one-cycle response pulse
- i_rdata  out  32  fetch data, valid with i_ready
- d_valid  in  1  data request; held until d_ready
- d_addr  in  32  data byte address
- d_wstrb  in  4  byte enables; nonzero = write, zero = read
- d_wdata  in  32  write data
- d_ready  out  1  one-cycle response pulse
- d_rdata  out  32  load data, valid with d_ready
- m_rready  out  1  memory read enable
- m_raddr  out  30  memory read word address
- m_waddr  out  30  memory write word address
- m_wdata  out  32  memory write data
- m_wstrb  out  4  memory byte write strobes
- m_rdata  in  32  memory read data, valid the cycle after m_rready
- err  out  1  one-cycle pulse, coincident with the faulting port's ready
- err_addr  out  32  address of the last faulting request; holds until the next fault

Behaviour:
- Reset values: all outputs 0, starvation counter 0, both response-pending flags 0, state IDLE. Reset may be asserted at any time; in-flight responses are discarded and no ready pulse follows.
- Per-port state: one pending flag, set in the grant cycle G and cleared in G+1.
- A port whose pending flag is set is masked from arbitration in G+1. This prevents a held valid from being re-granted, so each port has at most one grant every 2 cycles.
- The other port may be granted in the same cycle, so I and D interleave back-to-back.
- Eligibility: eligible_x = x_valid & ~pending_x.
- Arbitration:
  - Only one eligible: grant it.
  - Both eligible: grant D unless starve_cnt == STARVE_MAX, in which case grant I.
- Starvation counter:
  - Increments on each D grant made while I is eligible.
  - Clears on any I grant, and on any cycle where i_valid = 0.
  - Saturates at STARVE_MAX.
- Range check: addr[31:$clog2(MEMSIZE)] != 0 marks the request as faulting. A faulting request is granted normally, but no memory strobe is issued (m_rready = 0, m_wstrb = 0).
- Grant cycle G (combinational outputs):
  - m_raddr = m_waddr = addr[31:2] of the granted port.
  - Read: m_rready = 1.
  - Write: m_wstrb = d_wstrb, m_wdata = d_wdata; the write commits at the end of G.
  - No grant: m_rready = 0, m_wstrb = 0, addresses 0.
- Response cycle G+1:
  - x_ready = 1.
  - Read: x_rdata = m_rdata. Write or faulting request: x_rdata = 0.
  - Faulting request: err = 1, and err_addr is loaded with the faulting address at the end of G.
- Latency: exactly 1 cycle from grant to ready.
- I and D responses may coincide in one cycle only if they were granted in different earlier cycles; ports are independent.
- Protocol: valid, addr, wstrb and wdata are held until ready. A valid dropped after grant still receives its response.
- Byte offset addr[1:0] is ignored; alignment is the requester's responsibility.

Test Plan:
- Lone fetch, i_addr=0x10, memory word 4 = 0x00500093 → m_rready=1, m_raddr=4 in G; i_ready=1, i_rdata=0x00500093 in G+1; no regrant in G+1.
- Simultaneous I read 0x0 and D read 0x100 → D granted first, I granted next cycle. d_ready and i_ready pulse in consecutive cycles with the correct data.
- D write d_addr=0x20, wstrb=4'b0011, wdata=0xAABBCCDD, then D read 0x20 over prior word 0 → read returns 0x0000CCDD.
- STARVE_MAX=4 with d_valid and i_valid both held high → D, I-masked pattern. I is granted on the 5th contention at the latest, and the counter returns to 0.
- i_addr=0x00020000 (MEMSIZE=128KB) → no m_rready. i_ready=1 with err=1, i_rdata=0, err_addr=0x00020000 in G+1.
- resetb pulled low in the cycle after a D grant → d_ready stays 0 and all outputs are 0. After release, a fresh fetch at 0x0 completes normally.
